// File: rtl/serial_comparator.sv
`default_nettype none
// ============================================================================
// Module      : serial_comparator
// Description : Bit-serial, MSB-first unsigned magnitude comparator with
//               registered GT/LT/EQ flags, done strobe and bit count.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_comparator #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WIDTH-1:0]             A,
    input  logic [WIDTH-1:0]             B,
    output logic                         busy,
    output logic                         done,
    output logic                         A_gt_B,
    output logic                         A_lt_B,
    output logic                         A_eq_B,
    output logic [$clog2(WIDTH+1)-1:0]   cycles
);

    localparam int c_idx_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_cnt_w = $clog2(WIDTH+1);

    localparam logic [c_idx_w-1:0] c_msb_idx = c_idx_w'(WIDTH-1);
    localparam logic [c_cnt_w-1:0] c_width   = c_cnt_w'(WIDTH);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_compare = 2'd1;
    localparam logic [1:0] c_st_done    = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [c_idx_w-1:0] r_idx;
    logic               r_decided;
    logic               r_gt;
    logic               r_lt;
    logic               r_gt_out;
    logic               r_lt_out;
    logic               r_eq_out;
    logic [c_cnt_w-1:0] r_cycles;

    logic               w_bit_a;
    logic               w_bit_b;
    logic               w_bit_diff;
    logic               w_first_diff;
    logic               w_new_gt;
    logic               w_new_lt;
    logic               w_finish;
    logic [c_cnt_w-1:0] w_examined;

    // Once a differing bit has been seen, later bits must not alter gt/lt.
    always_comb begin
        w_bit_a      = r_a[r_idx];
        w_bit_b      = r_b[r_idx];
        w_bit_diff   = w_bit_a ^ w_bit_b;
        w_first_diff = w_bit_diff & ~r_decided;
        w_new_gt     = r_decided ? r_gt : (w_first_diff & w_bit_a);
        w_new_lt     = r_decided ? r_lt : (w_first_diff & w_bit_b);
        w_finish     = (r_idx == '0) || (EARLY_EXIT && w_first_diff);
        w_examined   = c_width - c_cnt_w'(r_idx);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:    if (start)    w_state_nxt = c_st_compare;
            c_st_compare: if (w_finish) w_state_nxt = c_st_done;
            c_st_done:                  w_state_nxt = c_st_idle;
            default:                    w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_decided <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
            r_gt_out  <= 1'b0;
            r_lt_out  <= 1'b0;
            r_eq_out  <= 1'b0;
            r_cycles  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_a       <= A;
                        r_b       <= B;
                        r_idx     <= c_msb_idx;
                        r_decided <= 1'b0;
                        r_gt      <= 1'b0;
                        r_lt      <= 1'b0;
                    end
                end
                c_st_compare: begin
                    if (w_first_diff) begin
                        r_decided <= 1'b1;
                        r_gt      <= w_new_gt;
                        r_lt      <= w_new_lt;
                    end
                    // Published flags only change on the edge entering DONE.
                    if (w_finish) begin
                        r_gt_out <= w_new_gt;
                        r_lt_out <= w_new_lt;
                        r_eq_out <= ~(w_new_gt | w_new_lt);
                        r_cycles <= w_examined;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (r_state != c_st_idle);
    assign done   = (r_state == c_st_done);
    assign A_gt_B = r_gt_out;
    assign A_lt_B = r_lt_out;
    assign A_eq_B = r_eq_out;
    assign cycles = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_serial_comparator.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_comparator
// Description : Directed + random bench; early-exit and fixed-latency DUTs
//               run side by side against a magnitude/latency model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_comparator;

    localparam int W  = 8;
    localparam int CW = $clog2(W+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;

    logic          busy_e, done_e, gt_e, lt_e, eq_e;
    logic [CW-1:0] cyc_e;
    logic          busy_f, done_f, gt_f, lt_f, eq_f;
    logic [CW-1:0] cyc_f;

    int n_cmp = 0;
    int n_err = 0;

    serial_comparator #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut_early (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy_e), .done(done_e), .A_gt_B(gt_e), .A_lt_B(lt_e),
        .A_eq_B(eq_e), .cycles(cyc_e)
    );

    serial_comparator #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut_fixed (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy_f), .done(done_f), .A_gt_B(gt_f), .A_lt_B(lt_f),
        .A_eq_B(eq_f), .cycles(cyc_f)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " busy_e"}, 32'(busy_e), 0);
        chk({tag, " done_e"}, 32'(done_e), 0);
        chk({tag, " flags_e"}, {29'd0, gt_e, lt_e, eq_e}, 0);
        chk({tag, " cyc_e"}, 32'(cyc_e), 0);
        chk({tag, " busy_f"}, 32'(busy_f), 0);
        chk({tag, " done_f"}, 32'(done_f), 0);
        chk({tag, " flags_f"}, {29'd0, gt_f, lt_f, eq_f}, 0);
        chk({tag, " cyc_f"}, 32'(cyc_f), 0);
    endtask

    // Model: flags from integer comparison; early-exit latency from the
    // position of the highest set bit of A^B.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inj_c, input logic [W-1:0] ia, input logic [W-1:0] ib);
        logic [W-1:0] x;
        logic [2:0]   exp_flags;
        int k_e, p;
        int dc_e, dc_f, nd_e, nd_f;
        logic [2:0] fl_e, fl_f;
        int cy_e, cy_f;

        x = a ^ b;
        p = -1;
        for (int i = 0; i < W; i++) if (x[i]) p = i;
        k_e = (p < 0) ? W : W - p;
        exp_flags = {a > b, a < b, a == b};

        dc_e = 0; dc_f = 0; nd_e = 0; nd_f = 0;
        fl_e = '0; fl_f = '0; cy_e = 0; cy_f = 0;

        A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0;
        A = W'($urandom); B = W'($urandom);
        for (int c = 1; c <= W + 3; c++) begin
            if (done_e) begin
                nd_e++;
                if (dc_e == 0) begin dc_e = c; fl_e = {gt_e, lt_e, eq_e}; cy_e = int'(cyc_e); end
            end
            if (done_f) begin
                nd_f++;
                if (dc_f == 0) begin dc_f = c; fl_f = {gt_f, lt_f, eq_f}; cy_f = int'(cyc_f); end
            end
            if (c == inj_c) begin
                start = 1'b1; A = ia; B = ib;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;

        chk({tag, " lat_e"}, dc_e, k_e + 1);
        chk({tag, " flags_e"}, 32'(fl_e), 32'(exp_flags));
        chk({tag, " cycles_e"}, cy_e, k_e);
        chk({tag, " ndone_e"}, nd_e, 1);
        chk({tag, " lat_f"}, dc_f, W + 1);
        chk({tag, " flags_f"}, 32'(fl_f), 32'(exp_flags));
        chk({tag, " cycles_f"}, cy_f, W);
        chk({tag, " ndone_f"}, nd_f, 1);
        chk({tag, " idle"}, {30'd0, busy_e, busy_f}, 0);
        chk({tag, " hold_e"}, {25'd0, gt_e, lt_e, eq_e, cyc_e}, {25'd0, exp_flags, CW'(k_e)});
        chk({tag, " hold_f"}, {25'd0, gt_f, lt_f, eq_f, cyc_f}, {25'd0, exp_flags, CW'(W)});
    endtask

    initial begin
        int nd;
        logic [W-1:0] ra, rb;

        // Reset, then idle
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        chk_idle_zero("reset");

        run_op("gt_msb",   8'h80, 8'h7F, 0, 8'h00, 8'h00);
        run_op("eq_5a",    8'h5A, 8'h5A, 0, 8'h00, 8'h00);
        run_op("lt_lsb",   8'h12, 8'h13, 0, 8'h00, 8'h00);
        run_op("gt_f00f",  8'hF0, 8'h0F, 0, 8'h00, 8'h00);
        run_op("lt_zero",  8'h00, 8'hFF, 0, 8'h00, 8'h00);

        // Start while busy in COMPARE, and in the shared DONE cycle
        run_op("inj_cmp",  8'h33, 8'h35, 3, 8'h01, 8'h02);
        run_op("inj_done", 8'hC3, 8'hC3, 9, 8'h01, 8'h02);

        // Reset in cycle 3 of a compare
        A = 8'h00; B = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_zero("midrst");
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            nd += int'(done_e) + int'(done_f);
            if (c == 0) tick(); else tick();
        end
        chk("midrst nodone", nd, 0);
        chk_idle_zero("midrst after");

        // rst and start together: nothing accepted
        A = 8'hAA; B = 8'h55; rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst_start busy", {30'd0, busy_e, busy_f}, 0);
        tick();
        chk("rst_start busy2", {30'd0, busy_e, busy_f}, 0);
        run_op("post_rst", 8'h9C, 8'h9E, 0, 8'h00, 8'h00);

        // Random operands: independent, equal, or single-bit difference
        for (int n = 0; n < 24; n++) begin
            ra = W'($urandom);
            case (n % 3)
                0:       rb = W'($urandom);
                1:       rb = ra;
                default: rb = ra ^ (W'(1) << $urandom_range(W-1, 0));
            endcase
            run_op($sformatf("rnd%0d", n), ra, rb, 0, 8'h00, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
